// File: rtl/reg_write_register_table.sv
// Register-write sequencer: takes a write instruction for reg_addr, assembles
// four payload bytes little-endian, issues a one-cycle strobe to the register
// bank and waits for its acknowledge. Read-only targets, byte starvation and a
// missing acknowledge are reported through write_error / error_code.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for instr_valid_reg_write; read-only targets rejected
// COLLECT  | gathering payload bytes 0..3, byte timer running
// STROBE   | single-cycle reg_write_strobe, ack timer loaded
// WAIT_ACK | waiting for reg_write_ack, ack timer running

module reg_write_register_table #(
   parameter logic [15:0] BYTE_TIMEOUT = 16'd1000,
   parameter logic [7:0]  ACK_TIMEOUT  = 8'd64
) (
   input  logic        sysClk,
   input  logic        sysRst_n,
   input  logic [7:0]  reg_addr,
   input  logic        instr_valid_reg_write,
   input  logic [7:0]  byte_in,
   input  logic        byte_in_valid,
   input  logic        reg_write_ack,
   output logic [7:0]  write_addr,
   output logic [31:0] write_vals,
   output logic        reg_write_strobe,
   output logic        write_done,
   output logic        write_error,
   output logic [1:0]  error_code,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      STROBE   = 2'd2,
      WAIT_ACK = 2'd3
   } state_t;

   localparam logic [1:0] ERR_READ_ONLY   = 2'b01;
   localparam logic [1:0] ERR_BYTE_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_ACK_TIMEOUT  = 2'b11;

   localparam logic [7:0] ADDR_STATUS = 8'h00;
   localparam logic [7:0] ADDR_ERROR  = 8'h04;

   // Timers count down to zero; loading N-1 makes the terminal count land
   // exactly N cycles after the load.
   localparam logic [15:0] BYTE_TC_LOAD = BYTE_TIMEOUT - 16'd1;
   localparam logic [15:0] ACK_TC_LOAD  = {8'h00, ACK_TIMEOUT} - 16'd1;

   state_t      state, state_nxt;
   logic [1:0]  byte_cnt, byte_cnt_nxt;
   logic [15:0] timer, timer_nxt;
   logic [7:0]  addr_nxt;
   logic [31:0] vals_nxt;
   logic        done_nxt;
   logic        error_nxt;
   logic [1:0]  code_nxt;

   // Strobe and busy decode straight from state so reset clears them at once.
   assign reg_write_strobe = (state == STROBE);
   assign busy             = (state != IDLE);

   // State, counters, timers and registered outputs.
   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         state       <= IDLE;
         byte_cnt    <= 2'd0;
         timer       <= 16'd0;
         write_addr  <= 8'h00;
         write_vals  <= 32'h0;
         write_done  <= 1'b0;
         write_error <= 1'b0;
         error_code  <= 2'b00;
      end else begin
         state       <= state_nxt;
         byte_cnt    <= byte_cnt_nxt;
         timer       <= timer_nxt;
         write_addr  <= addr_nxt;
         write_vals  <= vals_nxt;
         write_done  <= done_nxt;
         write_error <= error_nxt;
         error_code  <= code_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      timer_nxt    = timer;
      addr_nxt     = write_addr;
      vals_nxt     = write_vals;
      done_nxt     = 1'b0;
      error_nxt    = 1'b0;
      code_nxt     = error_code;

      case (state)
         IDLE: begin
            if (instr_valid_reg_write) begin
               if ((reg_addr == ADDR_STATUS) || (reg_addr == ADDR_ERROR)) begin
                  error_nxt = 1'b1;
                  code_nxt  = ERR_READ_ONLY;
               end else begin
                  addr_nxt     = reg_addr;
                  byte_cnt_nxt = 2'd0;
                  timer_nxt    = BYTE_TC_LOAD;
                  state_nxt    = COLLECT;
               end
            end
         end

         COLLECT: begin
            if (byte_in_valid) begin
               case (byte_cnt)
                  2'd0:    vals_nxt[7:0]   = byte_in;
                  2'd1:    vals_nxt[15:8]  = byte_in;
                  2'd2:    vals_nxt[23:16] = byte_in;
                  default: vals_nxt[31:24] = byte_in;
               endcase
               byte_cnt_nxt = byte_cnt + 2'd1;
               timer_nxt    = BYTE_TC_LOAD;
               if (byte_cnt == 2'b11) begin
                  state_nxt = STROBE;
               end
            end else if (timer == 16'd0) begin
               error_nxt = 1'b1;
               code_nxt  = ERR_BYTE_TIMEOUT;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - 16'd1;
            end
         end

         STROBE: begin
            timer_nxt = ACK_TC_LOAD;
            state_nxt = WAIT_ACK;
         end

         WAIT_ACK: begin
            if (reg_write_ack) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (timer == 16'd0) begin
               error_nxt = 1'b1;
               code_nxt  = ERR_ACK_TIMEOUT;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - 16'd1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: doc/reg_write_register_table.md
REG_WRITE_REGISTER_TABLE -- requirements
Module: reg_write_register_table

Interface
REQ-001 Parameter BYTE_TIMEOUT, default 16'd1000: max idle cycles between write-payload bytes before abort.
REQ-002 Parameter ACK_TIMEOUT, default 8'd64: max cycles waiting for reg_write_ack after the strobe.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- sysClk  input  1  system clock; all state changes on the rising edge.
- sysRst_n  input  1  asynchronous active-low reset.
- reg_addr  input  8  target register address from the instruction data buffer.
- instr_valid_reg_write  input  1  one-cycle pulse: write instruction for reg_addr.
- byte_in  input  8  payload byte from the SPI receive byte buffer.
- byte_in_valid  input  1  one-cycle qualifier for byte_in.
- reg_write_ack  input  1  target register has captured write_vals.
- write_addr  output  8  latched target address.
- write_vals  output  32  assembled payload.
- reg_write_strobe  output  1  one-cycle write request to the register bank.
- write_done  output  1  one-cycle pulse: write acknowledged.
- write_error  output  1  one-cycle pulse: write rejected or aborted.
- error_code  output  2  cause of the last error: 01 read-only address, 10 byte timeout, 11 ack timeout.
- busy  output  1  high in any state other than IDLE.

Function
REQ-004 FSM states SHALL be IDLE, COLLECT, STROBE and WAIT_ACK.
REQ-005 IDLE + instr_valid_reg_write, reg_addr not 8'h00/8'h04: latch write_addr <= reg_addr, clear byte count and timer, go to COLLECT next cycle.
REQ-006 IDLE + instr_valid_reg_write, reg_addr = 8'h00 or 8'h04 (read-only status/error): stay IDLE, pulse write_error next cycle, set error_code = 01.
REQ-007 byte_in_valid SHALL be ignored in IDLE, STROBE and WAIT_ACK, including when it coincides with the accepting instr_valid_reg_write.
REQ-008 COLLECT: each byte_in_valid stores byte_in little-endian: byte 0 -> write_vals[7:0], byte 1 -> [15:8], byte 2 -> [23:16], byte 3 -> [31:24].
REQ-009 The 2-bit byte count SHALL increment per accepted byte; the 4th byte (count 2'b11) moves to STROBE next cycle.
REQ-010 COLLECT timer: reset on each accepted byte, +1 otherwise.
- Timer reaching BYTE_TIMEOUT: go to IDLE, pulse write_error, error_code = 10.
- No strobe is issued on this abort.
REQ-011 STROBE: reg_write_strobe high for exactly one cycle, with write_addr/write_vals stable.
- Next state is always WAIT_ACK; the ack timer is cleared.
REQ-012 WAIT_ACK: reg_write_ack high -> pulse write_done, go to IDLE.
- reg_write_ack is sampled only in WAIT_ACK; an ack during the STROBE cycle is ignored.
REQ-013 WAIT_ACK without ack: timer +1 per cycle.
- Timer reaching ACK_TIMEOUT: pulse write_error, error_code = 11, go to IDLE.
REQ-014 instr_valid_reg_write while busy SHALL be dropped silently (no error, no state change).
REQ-015 write_addr and write_vals SHALL hold their values after completion until the next accepted instruction (write_vals retains any partial-byte updates).
REQ-016 write_done and write_error SHALL be mutually exclusive.
- Each pulses exactly once per instruction that leaves IDLE.
- An instruction rejected in IDLE pulses write_error only.
- error_code holds until the next error.
REQ-017 A new instruction MAY be accepted in the first cycle back in IDLE (back-to-back, no dead cycle beyond the state return).

Reset
REQ-018 sysRst_n low SHALL immediately force state IDLE and clear all outputs, counters and timers (write_vals = 32'h0, write_addr = 8'h00, error_code = 2'b00), including mid-COLLECT or mid-WAIT_ACK.
REQ-019 Deassertion SHALL take effect on the next sysClk edge, with no strobe, done or error pulse generated by the reset itself.

Verification
REQ-020 Normal write:
- Stimulus: addr 8'h08, bytes 11,22,33,44, ack 2 cycles after the strobe.
- Required: single strobe with write_vals = 32'h44332211, write_addr = 8'h08, write_done once, busy falls.
REQ-021 Read-only target:
- Stimulus: instr to addr 8'h04.
- Required: no strobe, write_error with error_code = 01, busy never rises.
REQ-022 Byte timeout:
- Stimulus: addr 8'h0C, 2 bytes, then silence.
- Required: write_error with error_code = 10 exactly BYTE_TIMEOUT cycles after the last byte, no strobe.
REQ-023 Ack timeout and early ack:
- Stimulus: ack asserted only in the STROBE cycle.
- Required: ack ignored, write_error with error_code = 11 after ACK_TIMEOUT cycles.
REQ-024 Reset and back-to-back:
- Stimulus: sysRst_n pulsed low after byte 3.
- Required: all outputs zero, no pulses.
- Stimulus: two full writes back-to-back, with a second instr_valid mid-COLLECT.
- Required: the mid-COLLECT instruction is dropped; both full writes complete correctly.
